apb_reg_bridge: RTL and testbench
=================================

APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 7, address width; DATA_WIDTH, default 32, data width; TAPS, default 72, fractional-decimator coefficient count; NUM_DENUM, default 5, coefficients per IIR notch; TIMEOUT, default 15, maximum register-file wait cycles.
REQ-002 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  reset.
REQ-003 SHALL have APB-side ports: PSEL  in  1  select; PENABLE  in  1  access phase; PWRITE  in  1  write=1; PADDR  in  ADDR_WIDTH  address; PWDATA  in  DATA_WIDTH  write data; PREADY  out  1  transfer done; PRDATA  out  DATA_WIDTH  read data; PSLVERR  out  1  error.
REQ-004 SHALL have register-file-side ports: FRAC_DECI_EN, IIR_EN, CTRL_EN, CIC_EN, FIR_EN  out  1 each  region select; RF_PWRITE  out  1; RF_PENABLE  out  1; RF_ADDR  out  ADDR_WIDTH; RF_WDATA  out  DATA_WIDTH; RF_PREADY  in  1; RF_PRDATA  in  DATA_WIDTH.
REQ-005 SHALL have status port ERR_CNT  out  8  saturating count of PSLVERR responses.

Function
REQ-006 SHALL decode addresses with default parameters as follows: 0-71 FRAC_DECI; 72-86 IIR; 87 CIC; 88-93 CTRL; 94-95 FRAC_DECI; 96-101 IIR; 102-103 CIC; 104-105 FIR; 106 and above unmapped.
REQ-007 SHALL derive all region bounds from TAPS and NUM_DENUM, not from literals.
REQ-008 SHALL implement FSM states IDLE, RF_SETUP, RF_ACCESS, RESP.
REQ-009 SHALL, in IDLE with PSEL=1 and PENABLE=0, latch PADDR, PWDATA, PWRITE and the decoded region; mapped addresses go to RF_SETUP, unmapped addresses go to RESP with error flagged.
REQ-010 SHALL, in RF_SETUP, drive exactly one region enable, RF_PENABLE=0, and the latched RF_ADDR, RF_WDATA and RF_PWRITE for one cycle, then go to RF_ACCESS.
REQ-011 SHALL, in RF_ACCESS, hold the region enable with RF_PENABLE=1; when RF_PREADY=1, capture RF_PRDATA on reads and go to RESP.
REQ-012 SHALL count RF_ACCESS cycles; if RF_PREADY is still 0 after TIMEOUT cycles, go to RESP with error flagged.
REQ-013 SHALL, in RESP, drive PREADY=1 for exactly one cycle; PRDATA carries captured data on a successful read and 0 otherwise; PSLVERR=1 only if error is flagged; then return to IDLE.
REQ-014 SHALL keep PREADY, PRDATA and PSLVERR registered and at 0 outside RESP.
REQ-015 SHALL give successful-transfer latency of PREADY high in the 4th cycle after APB setup, i.e. 2 APB wait states.
REQ-016 SHALL, if PSEL drops in any non-IDLE state, abort: deassert all RF outputs and enables next cycle, go to IDLE, no PREADY, no ERR_CNT change.
REQ-017 SHALL ignore a new PSEL setup that arrives while not in IDLE.
REQ-018 SHALL, at most once per transfer, increment ERR_CNT on each RESP with PSLVERR=1, saturating at 255.
REQ-019 SHALL keep all region enables at 0 in IDLE and RESP, and never assert more than one at a time.

Reset
REQ-020 SHALL, on rst_n low, asynchronously force state IDLE, timeout counter 0, ERR_CNT 0, and all outputs 0.
REQ-021 SHALL, on reset mid-transfer, discard the transfer; the first post-reset cycle is IDLE.

Structure
REQ-022 SHALL place the state enum, region enum, and region-bound localparams as functions of TAPS and NUM_DENUM in shared package dfe_pkg.
REQ-023 SHALL put address decode in combinational sub-module dfe_addr_decode (PADDR in, one-hot region plus unmapped flag out); the FSM, counters and output registers stay in apb_reg_bridge.

Verification
REQ-024 SHALL cover: write PADDR=71, PWDATA=0x000ABCDE, RF_PREADY returned at first RF_ACCESS -> FRAC_DECI_EN high 2 cycles, RF_PENABLE=1 in 2nd, PREADY 4th cycle, PSLVERR=0.
REQ-025 SHALL cover: read PADDR=87, RF_PRDATA=0x0000000C -> CIC_EN asserted, PRDATA=0x0000000C with PREADY, PSLVERR=0.
REQ-026 SHALL cover: access PADDR=110 -> no enable asserted, PREADY with PSLVERR=1, PRDATA=0, ERR_CNT 0->1.
REQ-027 SHALL cover: write PADDR=90 with RF_PREADY held 0 -> CTRL_EN held for 15 RF_ACCESS cycles, then PSLVERR=1 and enable dropped.
REQ-028 SHALL cover: PSEL dropped during RF_ACCESS -> FSM in IDLE next cycle, PREADY never asserted; separately rst_n pulse mid-transfer -> all outputs 0 immediately.
REQ-029 SHALL cover: 256 unmapped accesses -> ERR_CNT saturates at 255.

Source files
------------

// File: rtl/dfe_pkg.sv
// Shared types and address-map arithmetic for the DFE register bridge.
// Region bounds are derived from the filter geometry, so the map follows TAPS/NUM_DENUM.
package dfe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RF_SETUP,
    RF_ACCESS,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    RGN_FRAC_DECI,
    RGN_IIR,
    RGN_CTRL,
    RGN_CIC,
    RGN_FIR
  } region_t;

  localparam int unsigned NUM_REGIONS       = 5;
  localparam int unsigned DEFAULT_TAPS      = 72;
  localparam int unsigned DEFAULT_NUM_DENUM = 5;

  // Exclusive end address of each consecutive window, lowest address first.
  typedef struct packed {
    int unsigned frac0_end;
    int unsigned iir0_end;
    int unsigned cic0_end;
    int unsigned ctrl_end;
    int unsigned frac1_end;
    int unsigned iir1_end;
    int unsigned cic1_end;
    int unsigned fir_end;
  } bounds_t;

  function automatic bounds_t calc_bounds(input int unsigned taps, input int unsigned nd);
    bounds_t b;
    b.frac0_end = taps;
    b.iir0_end  = b.frac0_end + 3 * nd;
    b.cic0_end  = b.iir0_end + 1;
    b.ctrl_end  = b.cic0_end + nd + 1;
    b.frac1_end = b.ctrl_end + 2;
    b.iir1_end  = b.frac1_end + nd + 1;
    b.cic1_end  = b.iir1_end + 2;
    b.fir_end   = b.cic1_end + 2;
    return b;
  endfunction

endpackage

// File: rtl/apb_reg_bridge_if.sv
// APB bus bundle between the host and the register bridge.
interface apb_reg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/dfe_addr_decode.sv
// Combinational address decoder: one-hot region select plus unmapped flag.
module dfe_addr_decode
  import dfe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned TAPS       = DEFAULT_TAPS,
  parameter int unsigned NUM_DENUM  = DEFAULT_NUM_DENUM
) (
  input  logic [ADDR_WIDTH-1:0]  PADDR,
  output logic [NUM_REGIONS-1:0] region_oh,
  output logic                   unmapped
);

  localparam bounds_t B = calc_bounds(TAPS, NUM_DENUM);

  logic [31:0] addr;
  assign addr = 32'(PADDR);

  always_comb begin
    region_oh = '0;
    unmapped  = 1'b0;
    if      (addr < B.frac0_end) region_oh[RGN_FRAC_DECI] = 1'b1;
    else if (addr < B.iir0_end)  region_oh[RGN_IIR]       = 1'b1;
    else if (addr < B.cic0_end)  region_oh[RGN_CIC]       = 1'b1;
    else if (addr < B.ctrl_end)  region_oh[RGN_CTRL]      = 1'b1;
    else if (addr < B.frac1_end) region_oh[RGN_FRAC_DECI] = 1'b1;
    else if (addr < B.iir1_end)  region_oh[RGN_IIR]       = 1'b1;
    else if (addr < B.cic1_end)  region_oh[RGN_CIC]       = 1'b1;
    else if (addr < B.fir_end)   region_oh[RGN_FIR]       = 1'b1;
    else                         unmapped                 = 1'b1;
  end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB slave that forwards each transfer to one DFE register-file region,
// with wait-state timeout, abort on PSEL drop and a saturating error counter.
module apb_reg_bridge
  import dfe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAPS       = DEFAULT_TAPS,
  parameter int unsigned NUM_DENUM  = DEFAULT_NUM_DENUM,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb_reg_bridge_if.slave       apb,
  output logic                  FRAC_DECI_EN,
  output logic                  IIR_EN,
  output logic                  CTRL_EN,
  output logic                  CIC_EN,
  output logic                  FIR_EN,
  output logic                  RF_PWRITE,
  output logic                  RF_PENABLE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WDATA,
  input  logic                  RF_PREADY,
  input  logic [DATA_WIDTH-1:0] RF_PRDATA,
  output logic [7:0]            ERR_CNT
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  state_t                  state, state_d;
  logic [TCNT_W-1:0]       tcnt, tcnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic [NUM_REGIONS-1:0]  region_q, region_oh, en;
  logic                    unmapped;
  logic                    pready_q, pslverr_q;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic                    go_resp, resp_err;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    setup_hit, rf_active;

  dfe_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TAPS       (TAPS),
    .NUM_DENUM  (NUM_DENUM)
  ) u_decode (
    .PADDR     (apb.PADDR),
    .region_oh (region_oh),
    .unmapped  (unmapped)
  );

  assign setup_hit = (state == IDLE) && apb.PSEL && !apb.PENABLE;

  always_comb begin
    state_d   = state;
    tcnt_d    = tcnt;
    go_resp   = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    unique case (state)
      IDLE: begin
        if (setup_hit) begin
          if (unmapped) begin
            state_d  = RESP;
            go_resp  = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d = RF_SETUP;
          end
        end
      end
      RF_SETUP: begin
        tcnt_d  = '0;
        state_d = apb.PSEL ? RF_ACCESS : IDLE;
      end
      RF_ACCESS: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
        end else if (RF_PREADY) begin
          state_d   = RESP;
          go_resp   = 1'b1;
          resp_data = write_q ? '0 : RF_PRDATA;
        end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          state_d  = RESP;
          go_resp  = 1'b1;
          resp_err = 1'b1;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // APB response is registered on entry to RESP so it is high for that state only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      region_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      ERR_CNT   <= '0;
    end else begin
      state     <= state_d;
      tcnt      <= tcnt_d;
      pready_q  <= go_resp;
      pslverr_q <= go_resp & resp_err;
      prdata_q  <= go_resp ? resp_data : '0;
      if (setup_hit) begin
        addr_q   <= apb.PADDR;
        wdata_q  <= apb.PWDATA;
        write_q  <= apb.PWRITE;
        region_q <= region_oh;
      end
      if (go_resp && resp_err && (ERR_CNT != '1)) begin
        ERR_CNT <= ERR_CNT + 8'd1;
      end
    end
  end

  assign rf_active = (state == RF_SETUP) || (state == RF_ACCESS);
  assign en        = rf_active ? region_q : '0;

  assign FRAC_DECI_EN = en[RGN_FRAC_DECI];
  assign IIR_EN       = en[RGN_IIR];
  assign CTRL_EN      = en[RGN_CTRL];
  assign CIC_EN       = en[RGN_CIC];
  assign FIR_EN       = en[RGN_FIR];
  assign RF_PENABLE   = (state == RF_ACCESS);
  assign RF_PWRITE    = rf_active & write_q;
  assign RF_ADDR      = rf_active ? addr_q : '0;
  assign RF_WDATA     = rf_active ? wdata_q : '0;

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed self-checking bench for apb_reg_bridge with default parameters.
module tb_apb_reg_bridge;

  logic        clk;
  logic        rst_n;
  logic        FRAC_DECI_EN, IIR_EN, CTRL_EN, CIC_EN, FIR_EN;
  logic        RF_PWRITE, RF_PENABLE, RF_PREADY;
  logic [6:0]  RF_ADDR;
  logic [31:0] RF_WDATA, RF_PRDATA;
  logic [7:0]  ERR_CNT;
  logic [4:0]  en_vec;

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;

  apb_reg_bridge_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) apb ();

  apb_reg_bridge #(
    .ADDR_WIDTH (7),
    .DATA_WIDTH (32),
    .TAPS       (72),
    .NUM_DENUM  (5),
    .TIMEOUT    (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apb          (apb),
    .FRAC_DECI_EN (FRAC_DECI_EN),
    .IIR_EN       (IIR_EN),
    .CTRL_EN      (CTRL_EN),
    .CIC_EN       (CIC_EN),
    .FIR_EN       (FIR_EN),
    .RF_PWRITE    (RF_PWRITE),
    .RF_PENABLE   (RF_PENABLE),
    .RF_ADDR      (RF_ADDR),
    .RF_WDATA     (RF_WDATA),
    .RF_PREADY    (RF_PREADY),
    .RF_PRDATA    (RF_PRDATA),
    .ERR_CNT      (ERR_CNT)
  );

  assign en_vec = {FIR_EN, CIC_EN, CTRL_EN, IIR_EN, FRAC_DECI_EN};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_setup(input logic [6:0] addr, input logic wr, input logic [31:0] data);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PADDR   = addr;
    apb.PWRITE  = wr;
    apb.PWDATA  = data;
  endtask

  task automatic apb_release();
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
  endtask

  // Expected decode: bit0 FRAC_DECI, bit1 IIR, bit2 CTRL, bit3 CIC, bit4 FIR
  logic [6:0] dec_addr [17] = '{0, 71, 72, 86, 87, 88, 93, 94, 95, 96, 101, 102, 103, 104, 105, 106, 127};
  logic [4:0] dec_en   [17] = '{1, 1, 2, 2, 8, 4, 4, 1, 1, 2, 2, 8, 8, 16, 16, 0, 0};

  initial begin
    rst_n       = 1'b0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    RF_PREADY   = 1'b0;
    RF_PRDATA   = '0;
    tick();
    tick();
    check("rst_pready", apb.PREADY, 0);
    check("rst_en", en_vec, 0);
    check("rst_errcnt", ERR_CNT, 0);
    check("rst_rf_addr", RF_ADDR, 0);
    #2 rst_n = 1'b1;
    tick();

    // Write to 71 with immediate register-file ready
    apb_setup(7'd71, 1'b1, 32'h000A_BCDE);
    RF_PREADY = 1'b1;
    check("wr71_idle_en", en_vec, 0);
    tick();
    apb.PENABLE = 1'b1;
    check("wr71_setup_en", en_vec, 5'd1);
    check("wr71_setup_penable", RF_PENABLE, 0);
    check("wr71_setup_addr", RF_ADDR, 71);
    check("wr71_setup_wdata", RF_WDATA, 32'h000A_BCDE);
    check("wr71_setup_pwrite", RF_PWRITE, 1);
    check("wr71_setup_pready", apb.PREADY, 0);
    tick();
    check("wr71_access_en", en_vec, 5'd1);
    check("wr71_access_penable", RF_PENABLE, 1);
    check("wr71_access_pready", apb.PREADY, 0);
    tick();
    check("wr71_resp_pready", apb.PREADY, 1);
    check("wr71_resp_pslverr", apb.PSLVERR, 0);
    check("wr71_resp_prdata", apb.PRDATA, 0);
    check("wr71_resp_en", en_vec, 0);
    apb_release();
    tick();
    check("wr71_idle_pready", apb.PREADY, 0);

    // Read from 87 (CIC)
    apb_setup(7'd87, 1'b0, 32'h0);
    RF_PRDATA = 32'h0000_000C;
    tick();
    apb.PENABLE = 1'b1;
    check("rd87_setup_en", en_vec, 5'd8);
    check("rd87_setup_pwrite", RF_PWRITE, 0);
    tick();
    check("rd87_access_en", en_vec, 5'd8);
    tick();
    check("rd87_resp_pready", apb.PREADY, 1);
    check("rd87_resp_prdata", apb.PRDATA, 32'h0000_000C);
    check("rd87_resp_pslverr", apb.PSLVERR, 0);
    apb_release();
    tick();

    // Unmapped access to 110
    apb_setup(7'd110, 1'b0, 32'h0);
    RF_PRDATA = 32'hDEAD_BEEF;
    check("un110_errcnt_before", ERR_CNT, 0);
    tick();
    exp_err++;
    check("un110_en", en_vec, 0);
    check("un110_pready", apb.PREADY, 1);
    check("un110_pslverr", apb.PSLVERR, 1);
    check("un110_prdata", apb.PRDATA, 0);
    check("un110_errcnt", ERR_CNT, exp_err);
    apb_release();
    tick();
    check("un110_pslverr_clr", apb.PSLVERR, 0);

    // Timeout on write to 90; a stray setup mid-transfer must be ignored
    apb_setup(7'd90, 1'b1, 32'h1234_5678);
    RF_PREADY = 1'b0;
    tick();
    apb.PENABLE = 1'b1;
    check("to90_setup_en", en_vec, 5'd4);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to90_access_en", en_vec, 5'd4);
      check("to90_access_penable", RF_PENABLE, 1);
      check("to90_access_pready", apb.PREADY, 0);
      check("to90_access_addr", RF_ADDR, 90);
      if (i == 4) begin
        apb.PENABLE = 1'b0;
        apb.PADDR   = 7'd3;
      end else begin
        apb.PENABLE = 1'b1;
        apb.PADDR   = 7'd90;
      end
    end
    tick();
    exp_err++;
    check("to90_resp_pready", apb.PREADY, 1);
    check("to90_resp_pslverr", apb.PSLVERR, 1);
    check("to90_resp_en", en_vec, 0);
    check("to90_errcnt", ERR_CNT, exp_err);
    apb_release();
    tick();

    // PSEL dropped during RF_ACCESS
    apb_setup(7'd88, 1'b1, 32'h5555_0000);
    tick();
    apb.PENABLE = 1'b1;
    tick();
    check("abort_access_penable", RF_PENABLE, 1);
    apb_release();
    tick();
    check("abort_en", en_vec, 0);
    check("abort_penable", RF_PENABLE, 0);
    check("abort_addr", RF_ADDR, 0);
    check("abort_pwrite", RF_PWRITE, 0);
    check("abort_pready", apb.PREADY, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_pready_later", apb.PREADY, 0);
    end
    check("abort_errcnt", ERR_CNT, exp_err);

    // Reset pulse mid-transfer
    apb_setup(7'd104, 1'b1, 32'hAAAA_5555);
    tick();
    apb.PENABLE = 1'b1;
    tick();
    check("rstmid_fir_en", en_vec, 5'd16);
    rst_n = 1'b0;
    #1;
    exp_err = 0;
    check("rstmid_en", en_vec, 0);
    check("rstmid_penable", RF_PENABLE, 0);
    check("rstmid_pwrite", RF_PWRITE, 0);
    check("rstmid_addr", RF_ADDR, 0);
    check("rstmid_wdata", RF_WDATA, 0);
    check("rstmid_errcnt", ERR_CNT, exp_err);
    check("rstmid_pready", apb.PREADY, 0);
    apb_release();
    #2 rst_n = 1'b1;
    tick();
    check("rstmid_post_en", en_vec, 0);

    // Region boundary decode sweep
    for (int i = 0; i < 17; i++) begin
      apb_setup(dec_addr[i], 1'b0, 32'h0);
      RF_PREADY = 1'b1;
      RF_PRDATA = 32'h0000_1000 + 32'(i);
      tick();
      if (dec_en[i] != 5'd0) begin
        check("dec_en", en_vec, dec_en[i]);
        apb.PENABLE = 1'b1;
        tick();
        tick();
        check("dec_mapped_pslverr", apb.PSLVERR, 0);
        check("dec_mapped_prdata", apb.PRDATA, 32'h0000_1000 + 32'(i));
      end else begin
        exp_err++;
        check("dec_unmapped_pready", apb.PREADY, 1);
        check("dec_unmapped_pslverr", apb.PSLVERR, 1);
        check("dec_unmapped_errcnt", ERR_CNT, exp_err);
      end
      apb_release();
      tick();
    end

    // Error counter saturation
    for (int i = 0; i < 256; i++) begin
      apb_setup(7'd120, 1'b1, 32'h0);
      tick();
      if (exp_err < 255) exp_err++;
      apb_release();
      tick();
    end
    check("sat_errcnt", ERR_CNT, exp_err);
    check("sat_errcnt_255", ERR_CNT, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
